// File: rtl/dzcpu_mmu_dma.sv
// Memory-management stage behind the dzcpu MCU bus: FF46 DMA register, high RAM,
// pass-through to the shared external memory port, and the OAM DMA engine.
module dzcpu_mmu_dma #(
  parameter int unsigned DMA_LEN = 160,
  parameter logic [7:0]  OAM_HI  = 8'hFE
) (
  input  logic        iClock,
  input  logic        iReset_n,
  input  logic [15:0] iCpuAddr,
  input  logic [7:0]  iCpuData,
  input  logic        iCpuWe,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMemAddr,
  output logic [7:0]  oMemData,
  output logic        oMemWe,
  input  logic [7:0]  iMemData,
  output logic        oDmaActive
);

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  LAST_IDX     = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] dma_reg;
  logic [7:0] idx, idx_nxt;
  logic [7:0] src, src_nxt;
  logic [7:0] hram [0:126];

  logic       dma_hit;
  logic       dma_wr;
  logic       hram_hit;
  logic [6:0] hram_idx;
  logic       cpu_internal;

  // Echo RAM (E000-FDFF) folds onto work RAM as a DMA source.
  function automatic logic [7:0] src_map(input logic [7:0] v);
    return (v >= 8'hE0) ? (v - 8'h20) : v;
  endfunction

  assign dma_hit      = (iCpuAddr == DMA_REG_ADDR);
  assign dma_wr       = dma_hit && iCpuWe;
  assign hram_hit     = (iCpuAddr >= 16'hFF80) && (iCpuAddr != 16'hFFFF);
  assign hram_idx     = iCpuAddr[6:0];
  assign cpu_internal = dma_hit || hram_hit;
  assign oDmaActive   = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      src     <= '0;
      dma_reg <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      src   <= src_nxt;
      if (dma_wr) dma_reg <= iCpuData;
    end
  end

  // NOTE: HRAM is cleared on reset because software may rely on it reading
  // zero; that forces flops rather than a RAM macro for this small array.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < 127; i++) hram[i] <= '0;
    end else if (iCpuWe && hram_hit) begin
      hram[hram_idx] <= iCpuData;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    src_nxt   = src;
    unique case (state)
      S_IDLE: ;
      S_RD:   state_nxt = S_WR;
      S_WR: begin
        if (idx == LAST_IDX) begin
          state_nxt = S_IDLE;
        end else begin
          idx_nxt   = idx + 8'd1;
          state_nxt = S_RD;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // A register write restarts the engine from any state; a WR in flight
    // this cycle still drives the bus below and completes at this edge.
    if (dma_wr) begin
      state_nxt = S_RD;
      idx_nxt   = '0;
      src_nxt   = src_map(iCpuData);
    end
  end

  always_comb begin
    oMemAddr = iCpuAddr;
    oMemData = iCpuData;
    oMemWe   = iCpuWe && !cpu_internal;
    unique case (state)
      S_RD: begin
        oMemAddr = {src, idx};
        oMemWe   = 1'b0;
      end
      S_WR: begin
        oMemAddr = {OAM_HI, idx};
        oMemData = iMemData;
        oMemWe   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    if (dma_hit)               oCpuData = dma_reg;
    else if (hram_hit)         oCpuData = hram[hram_idx];
    else if (state == S_IDLE)  oCpuData = iMemData;
    else                       oCpuData = 8'hFF;
  end

endmodule

// File: doc/dzcpu_mmu_dma.md
# dzcpu_mmu_dma

Memory-management stage directly downstream of the dzcpu MCU bus: decodes every CPU address/data/write-enable cycle, serves the DMA register (0xFF46) and high RAM (0xFF80–0xFFFE) internally, and forwards all other accesses to the single shared external memory port. It also contains the OAM DMA engine. A write to 0xFF46 copies 160 bytes from `{V,8'h00}` into OAM at 0xFE00, using the same memory port, while the CPU is fenced off from the shared bus.

## Interface
Parameters:
- `DMA_LEN`, default 160: bytes per DMA transfer. Valid range 1..256.
- `OAM_HI`, default 8'hFE: high byte of the DMA destination.

Ports:
- `iClock`  in  1  system clock; all state updates on the rising edge.
- `iReset_n`  in  1  reset, asynchronous, active-low.
- `iCpuAddr`  in  16  CPU address (dzcpu `oMCUAddr`).
- `iCpuData`  in  8  CPU write data (dzcpu `oMCUData`).
- `iCpuWe`  in  1  CPU write enable (dzcpu `oMCUwe`).
- `oCpuData`  out  8  read data to CPU (dzcpu `iMCUData`); combinational.
- `oMemAddr`  out  16  external memory address.
- `oMemData`  out  8  external memory write data.
- `oMemWe`  out  1  external memory write enable.
- `iMemData`  in  8  external memory read data. Registered RAM: valid one cycle after the address.
- `oDmaActive`  out  1  high while the DMA engine owns the memory port.

## Operation
- Internal storage:
  - `rDmaReg[7:0]`: the 0xFF46 register.
  - `rHram[0:126]`: 127x8 array, index = `iCpuAddr - 16'hFF80`.
  - `rIdx[7:0]`: DMA byte counter.
  - `rSrc[7:0]`: DMA source high byte.
  - state register.
- FSM states:
  - **IDLE**
    - CPU write with `iCpuAddr==16'hFF46`: `rDmaReg<=iCpuData`, `rSrc<=src(iCpuData)`, `rIdx<=0`, go to RD.
  - **RD**
    - `oMemAddr={rSrc,rIdx}`, `oMemWe=0`.
    - Next state WR.
  - **WR**
    - `oMemAddr={OAM_HI,rIdx}`, `oMemWe=1`, `oMemData=iMemData` (the byte read in the preceding RD).
    - If `rIdx==DMA_LEN-1`: go to IDLE.
    - Else: `rIdx<=rIdx+1`, go to RD.
- Source mapping: `src(V) = (V>=8'hE0) ? V-8'h20 : V` (echo RAM folds to WRAM).
- `oDmaActive` = (state != IDLE).
- CPU decode, in priority order:
  - 0xFF46: reads return `rDmaReg`. Writes start or restart DMA in every state.
  - 0xFF80–0xFFFE: HRAM. Reads are combinational. Writes take effect at the edge. HRAM is always available, including during DMA.
  - Anything else, IDLE:
    - Pass-through: `oMemAddr=iCpuAddr`, `oMemData=iCpuData`, `oMemWe=iCpuWe`, `oCpuData=iMemData`.
  - Anything else, DMA active:
    - Reads return 8'hFF.
    - Writes are dropped: `oMemWe` is driven only by the FSM.
- Restart: a write to 0xFF46 during RD or WR aborts the current transfer. The WR in that same cycle still completes. Then `rIdx<=0`, the new `rSrc` is loaded, and the next state is RD.
- Address arithmetic is 16-bit with no carry beyond the low byte: `{rSrc,rIdx}` never crosses a 256-byte page.

## Timing
- Reset (`iReset_n=0`, asynchronous, effective immediately):
  - state=IDLE, `rIdx=0`, `rSrc=0`, `rDmaReg=8'h00`, all HRAM bytes 8'h00.
  - `oDmaActive=0`.
  - Outputs revert to pass-through of the CPU bus.
- Reset mid-DMA: the transfer is abandoned with no further memory writes. OAM keeps the bytes already written.
- DMA latency: FF46 write sampled at edge t → `oDmaActive=1` from edge t onward. The first RD occupies cycle t+1.
- Throughput: 2 cycles per byte. A transfer lasts exactly `2*DMA_LEN` cycles (320 by default). `oDmaActive` falls on the edge ending the last WR.
- The CPU-side read path is combinational for FF46, HRAM and the 8'hFF fence. The memory pass-through carries the RAM's one-cycle latency, which dzcpu covers with its sma/srm microcode ordering.

## Test plan
- Reset: drive `iReset_n` low mid-cycle with no clock edge → `oDmaActive=0` and FF46 reads 8'h00 immediately; HRAM[0xFF80] reads 8'h00.
- Basic DMA: preload memory 0xC000+i = i^8'h5A, CPU writes 8'hC0 to 0xFF46 → 320 active cycles. Alternating RD/WR addresses C000,FE00,C001,FE01,…; OAM 0xFE00+i = i^8'h5A for i=0..159. `oDmaActive` falls exactly 320 cycles after the write edge.
- Echo source: write 8'hE1 to 0xFF46 → RD addresses are 0xC100..0xC19F; FF46 reads back 8'hE1.
- Fence during DMA: CPU reads 0x0100 → 8'hFF. CPU writes 8'h33 to 0xC000 → no `oMemWe` pulse outside FSM WR cycles. CPU writes/reads 8'hA5 at 0xFF90 → 8'hA5 returned.
- Restart: write 8'hC0 to 0xFF46, then 8'hD0 at byte 10's WR cycle → byte 10 is written from 0xC00A, next RD is 0xD000. Transfer ends 320 cycles after the second write.
- Async reset at byte 80 → no further memory writes; after reset release, pass-through of CPU accesses to 0x8000 is restored.
